// File: rtl/song_sequencer.sv
// Song sequencer: walks one song in a synchronous ROM and dispatches note entries round-robin to the note players.
// Latency: a note is dispatched 3 cycles after its entry is fetched (FETCH, WAIT_ROM, DECODE), and the load pulse is registered.
// Backpressure: none downstream; play=0 freezes all state, beat ticks are dropped while paused, and load strobes are suppressed.
// Build option: define SONG_SEQUENCER_LOOP_EN to loop the song (song_done pulses once per pass) instead of stopping in DONE.
module song_sequencer #(
  parameter int NUM_PLAYERS = 3,
  parameter int SONG_LEN    = 32,
  localparam int IW = $clog2(SONG_LEN),
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play,
  input  logic [1:0]             song,
  input  logic                   beat,
  output logic [IW+1:0]          rom_addr,
  input  logic [15:0]            rom_data,
  output logic [5:0]             note_to_load,
  output logic [5:0]             duration_to_load,
  output logic [NUM_PLAYERS-1:0] load_new_note,
  output logic                   song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_DECODE,
    S_WAIT_BEATS,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [IW-1:0]          index_q;
  logic [PW-1:0]          ptr_q;
  logic [5:0]             cnt_q;
  logic [1:0]             song_q;
  logic [5:0]             note_q;
  logic [5:0]             dur_q;
  logic [NUM_PLAYERS-1:0] load_q;
  logic                   done_q;

  logic                   last_idx;
  logic [PW-1:0]          ptr_d;
  state_t                 end_state_d;
  logic [IW-1:0]          end_index_d;
  state_t                 adv_state_d;
  logic [IW-1:0]          adv_index_d;

  // Bits [2:0] of a song entry carry no meaning.
  logic unused_rom_bits;
  assign unused_rom_bits = ^rom_data[2:0];

  // The ROM address tracks the live song select so a song switch fetches from the new base at once.
  assign rom_addr         = {song, index_q};
  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign load_new_note    = load_q;
  assign song_done        = done_q;

  // Next-pointer and "step to next entry" targets, including end-of-song handling at the last index.
  always_comb begin
    last_idx = (index_q == IW'(SONG_LEN - 1));
    ptr_d    = (ptr_q == PW'(NUM_PLAYERS - 1)) ? '0 : ptr_q + PW'(1);
`ifdef SONG_SEQUENCER_LOOP_EN
    end_state_d = S_FETCH;
    end_index_d = '0;
`else
    end_state_d = S_DONE;
    end_index_d = index_q;
`endif
    adv_state_d = last_idx ? end_state_d : S_FETCH;
    adv_index_d = last_idx ? end_index_d : index_q + IW'(1);
  end

  // Main sequencer FSM: song change first, then pause, then normal stepping through the song.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      song_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      load_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      load_q <= '0;
`ifdef SONG_SEQUENCER_LOOP_EN
      done_q <= 1'b0;
`endif
      if (song != song_q) begin
        song_q  <= song;
        index_q <= '0;
        ptr_q   <= '0;
        cnt_q   <= '0;
        done_q  <= 1'b0;
        state_q <= play ? S_FETCH : S_IDLE;
      end else if (play) begin
        unique case (state_q)
          S_IDLE:     state_q <= S_FETCH;
          S_FETCH:    state_q <= S_WAIT_ROM;
          S_WAIT_ROM: state_q <= S_DECODE;
          S_DECODE: begin
            if (rom_data == 16'h0000) begin
              state_q <= end_state_d;
              index_q <= end_index_d;
              done_q  <= 1'b1;
            end else if (!rom_data[15]) begin
              note_q  <= rom_data[14:9];
              dur_q   <= rom_data[8:3];
              load_q  <= NUM_PLAYERS'(1) << ptr_q;
              ptr_q   <= ptr_d;
              state_q <= adv_state_d;
              index_q <= adv_index_d;
              if (last_idx) done_q <= 1'b1;
            end else if (rom_data[8:3] == 6'd0) begin
              state_q <= adv_state_d;
              index_q <= adv_index_d;
              if (last_idx) done_q <= 1'b1;
            end else begin
              cnt_q   <= rom_data[8:3];
              state_q <= S_WAIT_BEATS;
            end
          end
          S_WAIT_BEATS: begin
            if (beat) begin
              cnt_q <= cnt_q - 6'd1;
              if (cnt_q == 6'd1) begin
                state_q <= adv_state_d;
                index_q <= adv_index_d;
                if (last_idx) done_q <= 1'b1;
              end
            end
          end
          S_DONE:  state_q <= S_DONE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Upstream stage of the note_player array; walks one song stored in a synchronous song ROM, one 16-bit entry at a time.
- Note entries are dispatched round-robin to NUM_PLAYERS note players as a one-cycle load pulse with note and duration.
- Advance entries stall the sequencer for a counted number of 1/48 s beats, which is how chords and sequential melody are both expressed.
- Flags song_done at the end of the song.

Parameters:
- NUM_PLAYERS, 3, number of downstream note players; range 1..4.
- SONG_LEN, 32, entries per song; power of two, 2..64.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- play  input  1  1 = run, 0 = pause (all state frozen).
- song  input  2  song select; song base address = song*SONG_LEN.
- beat  input  1  one-cycle 1/48 s tick.
- rom_addr  output  2+log2(SONG_LEN)  song ROM address, {song, index}.
- rom_data  input  16  ROM word; valid the cycle after rom_addr is presented.
- note_to_load  output  6  note for the target player.
- duration_to_load  output  6  duration in beats.
- load_new_note  output  NUM_PLAYERS  one-hot, single-cycle load strobe.
- song_done  output  1  high while the current song has finished.

Behaviour:
- Entry format:
  - [15] kind: 0 = note, 1 = advance.
  - [14:9] note.
  - [8:3] duration or advance count.
  - [2:0] ignored.
  - An all-zero word is an end marker.
- Reset values: index 0, player pointer 0, state IDLE, beat counter 0, load_new_note 0, note_to_load 0, duration_to_load 0, song_done 0.
- rom_addr is combinational: {song, index}.
- States and transitions:
  - IDLE: if play, go to FETCH.
  - FETCH: present address; go to WAIT_ROM.
  - WAIT_ROM: go to DECODE; rom_data is sampled in DECODE.
  - DECODE:
    - End marker: go to DONE.
    - Note entry: register note and duration, pulse load_new_note[ptr] for exactly 1 cycle, set ptr = (ptr+1) mod NUM_PLAYERS, increment index, go to FETCH.
    - Advance entry with count 0: increment index, go to FETCH.
    - Advance entry with count n>0: load the counter with n, go to WAIT_BEATS.
  - WAIT_BEATS: each beat decrements the counter. On the beat where the counter goes 1->0, increment index and go to FETCH.
  - DONE: song_done = 1; stay until the song input changes.
- Index wrap: if index would pass SONG_LEN-1, go to DONE as if an end marker had been read.
- Throughput: note-to-note dispatch takes 3 cycles (FETCH, WAIT_ROM, DECODE).
- note_to_load and duration_to_load hold their last loaded values between pulses. They are valid in the same cycle as the load pulse.
- Pause (play=0):
  - State, index, counter and ptr are frozen.
  - A beat arriving while paused is ignored.
  - load_new_note is forced to 0.
  - A DECODE cycle that coincides with play=0 is re-executed when play returns; no pulse is lost or duplicated.
- Song change: any change of the song input, compared against a registered copy, takes priority over all other events in that cycle. It clears index, ptr, counter and song_done, then goes to FETCH if play=1, else IDLE. This applies in any state.
- Reset mid-operation forces the reset values immediately; no load pulse may be emitted in the reset cycle.

Optional Feature:
- Macro: SONG_SEQUENCER_LOOP_EN.
- Defined:
  - End marker or index wrap sets index to 0 and returns to FETCH instead of entering DONE.
  - ptr is kept.
  - song_done pulses high for exactly 1 cycle per loop.
- Undefined: DONE behaviour as above; song_done stays high.

Test Plan:
- Reset, then song=0, play=1, ROM[0]=note 10 dur 12, ROM[1]=note 20 dur 6, ROM[2]=0 -> load_new_note=001 with note 10/dur 12, then 3 cycles later 010 with note 20/dur 6, then song_done=1 and no further pulses.
- ROM[0]=advance 3, ROM[1]=note 5 -> no pulse until the 3rd beat after entering WAIT_BEATS; load pulse for note 5 occurs 3 cycles after that beat.
- NUM_PLAYERS=3, four consecutive note entries -> strobes 001, 010, 100, 001.
- play dropped for 10 cycles during WAIT_BEATS (count 2) with 2 beats delivered while paused -> counter unchanged; 2 further beats are needed after play=1 resumes.
- Song switched from 0 to 2 while in WAIT_BEATS -> next rom_addr = 2*SONG_LEN, ptr restarts at player 0, song_done=0.
- Loop macro defined, 2-entry song -> song_done pulses once, and rom_addr returns to the song base with no DONE stall.
